// File: rtl/n64_report_pkg.sv
// ============================================================================
// Module   : n64_report_pkg
// Purpose  : Shared types, constants and checksum helper for the controller
//            report framer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package n64_report_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
   localparam int         FRAME_LEN_NOCS = 5;
   localparam int         FRAME_LEN_CS   = 6;

   // Modulo-256 sum of the four snapshot bytes; the SYNC byte is not covered.
   function automatic logic [7:0] csum8(input logic [31:0] d);
      return d[31:24] + d[23:16] + d[15:8] + d[7:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/cntlr_report_framer.sv
// ============================================================================
// Module   : cntlr_report_framer
// Purpose  : Frames 32-bit controller snapshots as SYNC + 4 data bytes
//            (+ CSUM when REPORT_CHECKSUM_EN is defined) onto a valid/ready
//            byte link, with one latest-wins pending snapshot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cntlr_report_framer
   import n64_report_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
   parameter int         DROP_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           cntlr_data,
   input  logic                  cntlr_data_rdy,
   output logic [7:0]            tx_byte,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

`ifdef REPORT_CHECKSUM_EN
   localparam int c_frame_len = FRAME_LEN_CS;
`else
   localparam int c_frame_len = FRAME_LEN_NOCS;
`endif
   localparam logic [2:0] c_last = 3'(c_frame_len - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [2:0]            r_idx;
   logic [2:0]            w_idx_nxt;
   logic [31:0]           r_frame;
   logic [31:0]           r_pend;
   logic                  r_pend_vld;
   logic [DROP_CNT_W-1:0] r_drop_cnt;

   logic                  w_sending;
   logic                  w_xfer;
   logic                  w_at_last;
   logic                  w_src_avail;
   logic                  w_load;
   logic [31:0]           w_frame_src;

   assign w_sending   = (r_state == SEND);
   assign w_xfer      = w_sending && tx_ready;
   assign w_at_last   = (r_idx == c_last);
   assign w_src_avail = r_pend_vld || cntlr_data_rdy;
   // A new frame is captured either from idle or at acceptance of the last byte.
   assign w_load      = (!w_sending && w_src_avail) ||
                        (w_xfer && w_at_last && w_src_avail);
   assign w_frame_src = r_pend_vld ? r_pend : cntlr_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         IDLE: begin
            if (w_src_avail) begin
               w_state_nxt = SEND;
               w_idx_nxt   = 3'd0;
            end
         end
         SEND: begin
            if (w_xfer) begin
               if (w_at_last) begin
                  w_idx_nxt   = 3'd0;
                  w_state_nxt = w_src_avail ? SEND : IDLE;
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_idx_nxt   = 3'd0;
         end
      endcase
   end

   always_comb begin
      tx_valid = w_sending;
      busy     = w_sending || r_pend_vld;
      drop_cnt = r_drop_cnt;
      tx_byte  = 8'h00;
      if (w_sending) begin
         case (r_idx)
            3'd0:    tx_byte = SYNC_BYTE;
            3'd1:    tx_byte = r_frame[31:24];
            3'd2:    tx_byte = r_frame[23:16];
            3'd3:    tx_byte = r_frame[15:8];
            3'd4:    tx_byte = r_frame[7:0];
`ifdef REPORT_CHECKSUM_EN
            3'd5:    tx_byte = csum8(r_frame);
`endif
            default: tx_byte = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame    <= 32'd0;
         r_pend     <= 32'd0;
         r_pend_vld <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (w_load) begin
            r_frame <= w_frame_src;
         end
         if (cntlr_data_rdy) begin
            r_pend     <= cntlr_data;
            // A strobe framed directly from idle leaves nothing pending.
            r_pend_vld <= !(w_load && !r_pend_vld);
            if (r_pend_vld && !w_load && (r_drop_cnt != '1)) begin
               r_drop_cnt <= r_drop_cnt + 1'b1;
            end
         end else if (w_load) begin
            r_pend_vld <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cntlr_report_framer.sv
// ============================================================================
// Module   : tb_cntlr_report_framer
// Purpose  : Directed self-checking bench for cntlr_report_framer against a
//            byte-queue reference model (honours REPORT_CHECKSUM_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cntlr_report_framer;

`ifdef REPORT_CHECKSUM_EN
   localparam int FL = 6;
`else
   localparam int FL = 5;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cntlr_data = 32'd0;
   logic        cntlr_data_rdy = 1'b0;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        busy;
   logic [7:0]  drop_cnt;

   cntlr_report_framer #(
      .SYNC_BYTE  (8'hA5),
      .DROP_CNT_W (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cntlr_data     (cntlr_data),
      .cntlr_data_rdy (cntlr_data_rdy),
      .tx_byte        (tx_byte),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .busy           (busy),
      .drop_cnt       (drop_cnt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
   endtask

   // Reference model: outstanding bytes of the current frame, one pending slot.
   logic [7:0]  m_q[$];
   logic [31:0] m_pend     = 32'd0;
   bit          m_pend_vld = 1'b0;
   int          m_drop     = 0;
   bit          m_direct;
   logic [7:0]  acc_log[$];

   task automatic model_push_frame(input logic [31:0] d);
      int s;
      m_q.push_back(8'hA5);
      for (int b = 3; b >= 0; b--) m_q.push_back(d[8*b +: 8]);
      if (FL == 6) begin
         s = int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0]);
         m_q.push_back(8'(s % 256));
      end
   endtask

   always @(posedge clk) begin
      if (!rst && tx_valid && tx_ready) acc_log.push_back(tx_byte);
      if (rst) begin
         m_q.delete();
         m_pend_vld = 1'b0;
         m_drop     = 0;
      end else begin
         m_direct = 1'b0;
         if (m_q.size() > 0 && tx_ready) void'(m_q.pop_front());
         if (m_q.size() == 0 && (m_pend_vld || cntlr_data_rdy)) begin
            if (m_pend_vld) begin
               model_push_frame(m_pend);
               m_pend_vld = 1'b0;
            end else begin
               model_push_frame(cntlr_data);
               m_direct = 1'b1;
            end
         end
         if (cntlr_data_rdy && !m_direct) begin
            if (m_pend_vld && m_drop < 255) m_drop++;
            m_pend     = cntlr_data;
            m_pend_vld = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_q.size() > 0});
         chk("tx_byte", {24'd0, tx_byte}, (m_q.size() > 0) ? {24'd0, m_q[0]} : 32'd0);
         chk("busy", {31'd0, busy}, {31'd0, (m_q.size() > 0) || m_pend_vld});
         chk("drop_cnt", {24'd0, drop_cnt}, 32'(m_drop));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || tx_valid) && n < 200) begin
         step();
         n++;
      end
      n_chk++;
      if (n < 200) n_pass++;
      else $display("FAIL wait_idle: actual=timeout required=idle");
   endtask

   task automatic check_frame(input string nm, input int base, input logic [31:0] d,
                              input logic [7:0] cs);
      logic [7:0] exp[6];
      exp[0] = 8'hA5;
      exp[1] = d[31:24];
      exp[2] = d[23:16];
      exp[3] = d[15:8];
      exp[4] = d[7:0];
      exp[5] = cs;
      for (int i = 0; i < FL; i++) begin
         if (base + i < acc_log.size())
            chk(nm, {24'd0, acc_log[base + i]}, {24'd0, exp[i]});
         else
            chk(nm, 32'hFFFF_FFFF, {24'd0, exp[i]});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      rst = 1'b1;
      step();
      chk_en = 1'b1;
      step();
      step();
      chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
      rst = 1'b0;
      step();

      // Single snapshot, one-cycle latency to SYNC
      acc_log.delete();
      tx_ready = 1'b1;
      cntlr_data = 32'h1234_5678;
      cntlr_data_rdy = 1'b1;
      step();
      cntlr_data_rdy = 1'b0;
      chk("latency_valid", {31'd0, tx_valid}, 32'd1);
      chk("latency_sync", {24'd0, tx_byte}, 32'h0000_00A5);
      wait_idle();
      chk("single_len", 32'(acc_log.size()), 32'(FL));
      check_frame("single_bytes", 0, 32'h1234_5678, 8'h14);

      // Backpressure: tx_ready 1010...
      acc_log.delete();
      cntlr_data = 32'hAABB_CCDD;
      cntlr_data_rdy = 1'b1;
      step();
      cntlr_data_rdy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tx_ready = (i % 2 == 0);
         step();
      end
      tx_ready = 1'b1;
      wait_idle();
      chk("bp_len", 32'(acc_log.size()), 32'(FL));
      check_frame("bp_bytes", 0, 32'hAABB_CCDD, 8'h0E);

      // Three strobes: first starts a frame, second pends, third overwrites it
      acc_log.delete();
      cntlr_data = 32'h1111_1111;
      cntlr_data_rdy = 1'b1;
      step();
      cntlr_data = 32'h2222_2222;
      step();
      cntlr_data = 32'h3333_3333;
      step();
      cntlr_data_rdy = 1'b0;
      wait_idle();
      chk("overwrite_drop", {24'd0, drop_cnt}, 32'd1);
      chk("overwrite_len", 32'(acc_log.size()), 32'(2 * FL));
      check_frame("overwrite_f1", 0, 32'h1111_1111, 8'h44);
      check_frame("overwrite_f2", FL, 32'h3333_3333, 8'hCC);

      // Strobe coinciding with last-byte acceptance: no idle gap
      acc_log.delete();
      cntlr_data = 32'h1234_5678;
      cntlr_data_rdy = 1'b1;
      step();
      cntlr_data_rdy = 1'b0;
      repeat (FL - 1) step();
      cntlr_data = 32'hCAFE_BABE;
      cntlr_data_rdy = 1'b1;
      step();
      cntlr_data_rdy = 1'b0;
      chk("b2b_prev_len", 32'(acc_log.size()), 32'(FL));
      chk("b2b_valid", {31'd0, tx_valid}, 32'd1);
      chk("b2b_sync", {24'd0, tx_byte}, 32'h0000_00A5);
      wait_idle();
      check_frame("b2b_f2", FL, 32'hCAFE_BABE, 8'h40);

      // Saturation of drop counter
      tx_ready = 1'b0;
      for (int i = 0; i < 300; i++) begin
         cntlr_data = $urandom;
         cntlr_data_rdy = 1'b1;
         step();
      end
      cntlr_data_rdy = 1'b0;
      chk("drop_saturate", {24'd0, drop_cnt}, 32'h0000_00FF);
      tx_ready = 1'b1;
      wait_idle();
      chk("drop_hold", {24'd0, drop_cnt}, 32'h0000_00FF);

      // Reset mid-frame at byte idx 2, then a fresh frame
      cntlr_data = 32'h8765_4321;
      cntlr_data_rdy = 1'b1;
      step();
      cntlr_data_rdy = 1'b0;
      step();
      step();
      chk("mid_idx2", {24'd0, tx_byte}, 32'h0000_0065);
      rst = 1'b1;
      step();
      chk("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
      chk("mid_rst_drop", {24'd0, drop_cnt}, 32'd0);
      rst = 1'b0;
      step();
      acc_log.delete();
      cntlr_data = 32'h0BAD_F00D;
      cntlr_data_rdy = 1'b1;
      step();
      cntlr_data_rdy = 1'b0;
      wait_idle();
      chk("fresh_len", 32'(acc_log.size()), 32'(FL));
      check_frame("fresh_bytes", 0, 32'h0BAD_F00D, 8'hB5);

      step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
